bcd_count_ctrl: RTL and testbench

//  Run-control sequencer for a synchronous multi-digit BCD (mod-10 per digit) counter.

---
 rtl/bcd_count_ctrl.sv | 165 ++++++++++++++++
 tb/tb_bcd_count_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_count_ctrl.sv
// ---------------------------------------------------------------------------
// bcd_count_ctrl
//   Run-control sequencer around a DIGITS-wide synchronous BCD counter.
//   Accepts start/stop/clear/load commands and a tick qualifier, detects a
//   programmable terminal count and reports the all-9s -> all-0s wrap.
//
// Parameters
//   DIGITS    number of BCD digits (count width = 4*DIGITS)
//
// Ports
//   clk       clock, all state updates on the rising edge
//   rst       synchronous active-high reset, overrides every command
//   start     run / resume / restart
//   stop      pause (RUN -> HOLD)
//   clear     abort to IDLE with count 0 (highest priority command)
//   load      load load_val into count (IDLE/HOLD/DONE only)
//   load_val  BCD preset; a digit above 9 loads as 0
//   term_val  BCD terminal value; 0 selects free-run
//   tick      count-enable qualifier, counted only while in RUN
//   count     registered BCD count
//   running   high while in RUN
//   done      one-cycle pulse after the terminal tick
//   ovf       one-cycle pulse after the 9..9 -> 0..0 wrap
//   state_o   IDLE=0, RUN=1, HOLD=2, DONE=3
//
// Configuration
//   AUTO_RELOAD_EN  when defined, the terminal tick reloads count to 0 and
//                   the counter keeps running (DONE is never entered).
// ---------------------------------------------------------------------------
module bcd_count_ctrl #(
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic [4*DIGITS-1:0]   term_val,
  input  logic                  tick,
  output logic [4*DIGITS-1:0]   count,
  output logic                  running,
  output logic                  done,
  output logic                  ovf,
  output logic [1:0]            state_o
);

  localparam int W = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t         state_reg, state_next;
  logic [W-1:0]   count_reg, count_next;
  logic           done_reg, done_next;
  logic           ovf_reg, ovf_next;

  logic [W-1:0]   inc_val;
  logic [W-1:0]   load_clean;
  logic [DIGITS:0] carry;
  logic           wrap;
  logic           term_hit;

  // Ripple-carry BCD incrementer: carry enters digit 0 and propagates
  // through every digit currently at 9.
  assign carry[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] digit;
      logic [3:0] ld_digit;

      assign digit    = count_reg[4*gi +: 4];
      assign ld_digit = load_val[4*gi +: 4];

      assign inc_val[4*gi +: 4] = !carry[gi]        ? digit :
                                  (digit == 4'd9)   ? 4'd0  :
                                                      4'(digit + 4'd1);
      assign carry[gi+1] = carry[gi] & (digit == 4'd9);

      // Keeps the count register valid BCD at all times.
      assign load_clean[4*gi +: 4] = (ld_digit > 4'd9) ? 4'd0 : ld_digit;
    end
  endgenerate

  assign wrap = carry[DIGITS];

  // inc_val is always valid BCD, so a term_val digit above 9 can never match.
  assign term_hit = (term_val != '0) && (inc_val == term_val);

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    done_next  = 1'b0;
    ovf_next   = 1'b0;

    if (clear) begin
      state_next = IDLE;
      count_next = '0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (load)       count_next = load_clean;
          else if (start) state_next = RUN;
        end
        RUN: begin
          // load and start have no effect here; stop is still honoured.
          if (tick) begin
            count_next = inc_val;
            ovf_next   = wrap;
            if (term_hit) begin
              done_next = 1'b1;
`ifdef AUTO_RELOAD_EN
              count_next = '0;
`else
              state_next = DONE;
`endif
            end
          end
          // A same-cycle tick is counted first; reaching terminal wins over stop.
          if (stop && state_next == RUN) state_next = HOLD;
        end
        HOLD: begin
          if (load)       count_next = load_clean;
          else if (start) state_next = RUN;
        end
        DONE: begin
          if (load) begin
            count_next = load_clean;
          end else if (start) begin
            count_next = '0;
            state_next = RUN;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      count_reg <= '0;
      done_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      done_reg  <= done_next;
      ovf_reg   <= ovf_next;
    end
  end

  assign count   = count_reg;
  assign running = (state_reg == RUN);
  assign done    = done_reg;
  assign ovf     = ovf_reg;
  assign state_o = state_reg;

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bcd_count_ctrl
//   Directed scenarios followed by a randomized run of bcd_count_ctrl
//   (DIGITS=2). The reference model keeps the count as a plain integer
//   0..99 and converts to BCD only for comparison.
// ---------------------------------------------------------------------------
module tb_bcd_count_ctrl;

  localparam int D   = 2;
  localparam int W   = 4 * D;
  localparam int MOD = 100;

  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_HOLD = 2;
  localparam int S_DONE = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         clear = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] term_val = '0;
  logic         tick = 1'b0;
  logic [W-1:0] count;
  logic         running;
  logic         done;
  logic         ovf;
  logic [1:0]   state_o;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state
  int m_state = S_IDLE;
  int m_cnt   = 0;
  bit m_done  = 1'b0;
  bit m_ovf   = 1'b0;

  bcd_count_ctrl #(.DIGITS(D)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .clear    (clear),
    .load     (load),
    .load_val (load_val),
    .term_val (term_val),
    .tick     (tick),
    .count    (count),
    .running  (running),
    .done     (done),
    .ovf      (ovf),
    .state_o  (state_o)
  );

  always #5 clk = ~clk;

  // BCD preset to integer, invalid digits read as 0.
  function automatic int load_to_int(logic [W-1:0] v);
    int r = 0;
    int scale = 1;
    for (int i = 0; i < D; i++) begin
      int d = int'(v[4*i +: 4]);
      if (d > 9) d = 0;
      r += d * scale;
      scale *= 10;
    end
    return r;
  endfunction

  // BCD terminal to integer; -1 when any digit is invalid (never matches).
  function automatic int term_to_int(logic [W-1:0] v);
    int r = 0;
    int scale = 1;
    for (int i = 0; i < D; i++) begin
      int d = int'(v[4*i +: 4]);
      if (d > 9) return -1;
      r += d * scale;
      scale *= 10;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] int_to_bcd(int x);
    logic [W-1:0] r = '0;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs the DUT sees.
  task automatic model_edge();
    int t;
    int n;
    if (rst) begin
      m_state = S_IDLE; m_cnt = 0; m_done = 0; m_ovf = 0;
      return;
    end
    m_done = 0;
    m_ovf  = 0;
    t = term_to_int(term_val);
    if (clear) begin
      m_state = S_IDLE;
      m_cnt   = 0;
    end else begin
      case (m_state)
        S_IDLE, S_HOLD: begin
          if (load)       m_cnt = load_to_int(load_val);
          else if (start) m_state = S_RUN;
        end
        S_RUN: begin
          if (tick) begin
            n = m_cnt + 1;
            if (n == MOD) begin
              n = 0;
              m_ovf = 1;
            end
            m_cnt = n;
            if (term_val != '0 && n == t) begin
              m_done = 1;
`ifdef AUTO_RELOAD_EN
              m_cnt = 0;
`else
              m_state = S_DONE;
`endif
            end
          end
          if (stop && m_state == S_RUN) m_state = S_HOLD;
        end
        default: begin
          if (load) begin
            m_cnt = load_to_int(load_val);
          end else if (start) begin
            m_cnt   = 0;
            m_state = S_RUN;
          end
        end
      endcase
    end
  endtask

  // One clock: update model at the edge, compare all outputs 2 ns later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #2;
    check("count",   count,            int_to_bcd(m_cnt));
    check("state_o", W'(state_o),      W'(m_state));
    check("running", W'(running),      W'(m_state == S_RUN));
    check("done",    W'(done),         W'(m_done));
    check("ovf",     W'(ovf),          W'(m_ovf));
  endtask

  task automatic idle_inputs();
    start = 0; stop = 0; clear = 0; load = 0; tick = 0; rst = 0;
  endtask

  initial begin
    // reset
    rst = 1;
    step();
    check("rst_count", count, 8'h00);
    check("rst_state", W'(state_o), W'(0));

    // 1: count 00..23 to terminal
    idle_inputs();
    term_val = 8'h23;
    start = 1;
    step();
    start = 0; tick = 1;
    for (int i = 0; i < 40 && m_state != S_DONE; i++) step();
    check("t1_count", count, 8'h23);
    check("t1_state", W'(state_o), W'(3));
    check("t1_running", W'(running), W'(0));
    check("t1_done", W'(done), W'(1));
    step();
    check("t1_done_end", W'(done), W'(0));
    check("t1_frozen", count, 8'h23);

    // 2: 09 -> 10 carry; 99 -> 00 wrap with free-run
    idle_inputs(); clear = 1; step();
    idle_inputs(); load = 1; load_val = 8'h09; step();
    idle_inputs(); start = 1; step();
    idle_inputs(); tick = 1; step();
    check("t2_carry", count, 8'h10);
    idle_inputs(); stop = 1; step();
    idle_inputs(); load = 1; load_val = 8'h99; term_val = 8'h00; step();
    idle_inputs(); start = 1; step();
    idle_inputs(); tick = 1; step();
    check("t2_wrap", count, 8'h00);
    check("t2_ovf", W'(ovf), W'(1));
    idle_inputs(); step();
    check("t2_ovf_end", W'(ovf), W'(0));

    // 3: hold ignores ticks, resume counts again
    idle_inputs(); tick = 1;
    for (int i = 0; i < 5; i++) step();
    idle_inputs(); stop = 1; step();
    idle_inputs(); tick = 1;
    for (int i = 0; i < 4; i++) step();
    check("t3_hold_count", count, 8'h05);
    check("t3_hold_state", W'(state_o), W'(2));
    idle_inputs(); start = 1; step();
    idle_inputs(); tick = 1; step();
    check("t3_resume", count, 8'h06);

    // 4: clear beats load/start; load ignored in RUN
    for (int i = 0; i < 6; i++) step();
    idle_inputs(); clear = 1; start = 1; load = 1; load_val = 8'h55; step();
    check("t4_clear_count", count, 8'h00);
    check("t4_clear_state", W'(state_o), W'(0));
    idle_inputs(); start = 1; step();
    idle_inputs(); load = 1; load_val = 8'h40; step();
    check("t4_load_in_run", count, 8'h00);

    // 5: reset mid-run
    idle_inputs(); tick = 1;
    for (int i = 0; i < 17; i++) step();
    check("t5_pre", count, 8'h17);
    rst = 1; step();
    check("t5_count", count, 8'h00);
    check("t5_state", W'(state_o), W'(0));

`ifdef AUTO_RELOAD_EN
    // 6: auto reload period 3
    idle_inputs(); term_val = 8'h03; start = 1; step();
    idle_inputs(); tick = 1;
    for (int i = 0; i < 6; i++) step();
    check("t6_running", W'(running), W'(1));
`endif

    // invalid digits: load A7 -> 07, terminal 1A never matches
    idle_inputs(); load = 1; load_val = 8'hA7; term_val = 8'h1A; step();
    check("bad_load", count, 8'h07);
    idle_inputs(); start = 1; step();
    idle_inputs(); tick = 1;
    for (int i = 0; i < 12; i++) step();

    // randomized run
    for (int i = 0; i < 600; i++) begin
      idle_inputs();
      tick  = ($urandom_range(99) < 70);
      start = ($urandom_range(99) < 10);
      stop  = ($urandom_range(99) < 5);
      clear = ($urandom_range(99) < 2);
      load  = ($urandom_range(99) < 6);
      rst   = ($urandom_range(199) < 1);
      load_val = 8'($urandom);
      if ($urandom_range(99) < 5) begin
        case ($urandom_range(5))
          0: term_val = 8'h00;
          1: term_val = 8'h05;
          2: term_val = 8'h23;
          3: term_val = 8'h99;
          4: term_val = 8'hA3;
          default: term_val = 8'h15;
        endcase
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
